rover_motor_pwm: RTL and testbench
==================================

# rover_motor_pwm

Downstream drive stage for the rover's line-follow steering logic. Consumes the steering command bus (4-bit H-bridge direction pairs plus 2-bit enable) and produces the physical H-bridge inputs, with per-motor soft-start duty ramping, PWM on the bridge enables, and enforced dead time on every direction reversal or stop. Each motor has an independent channel; the PWM counter is shared.

## Interface
- PWM_BITS, 8, width of the PWM counter and duty registers; period = 2^PWM_BITS clocks
- DUTY_MAX, 200, run duty, 1..2^PWM_BITS-1
- RAMP_DIV, 1000, clocks per +1 duty step during ramp, >=1
- DEADTIME, 50, clocks both bridge inputs are held low on stop/reversal, >=1
- clk  input  1  system clock; the only clock
- rst_n  input  1  reset, asynchronous, active-low
- motor_in  input  4  command pairs: [3:2] left motor, [1:0] right motor; asynchronous to clk
- motor_en  input  2  command enables: [1] left, [0] right; asynchronous to clk
- hb_in  output  4  H-bridge direction pins, same bit mapping as motor_in
- hb_en  output  2  H-bridge enable pins, PWM-modulated
- busy  output  2  per channel, high while in DEAD

## Operation
- motor_in and motor_en pass through a two-flop synchronizer; the FSM sees only synchronized values.
- Per-channel decode of pair {a,b}: 01 = dir A, 10 = dir B, 00 or 11 = coast. Command is "go" when channel enable = 1 and pair is 01 or 10; otherwise "stop".
- Shared pwm_cnt: free-running, PWM_BITS wide, wraps 2^PWM_BITS-1 -> 0.
- Per-channel registers: state, dir (latched 2-bit pair), duty (PWM_BITS), ramp_cnt, dead_cnt.
- States, per channel:
  - IDLE: hb pair 00, en 0, duty 0. Go -> RAMP: latch dir, duty 0, ramp_cnt 0.
  - RAMP: hb pair = dir. ramp_cnt counts 0..RAMP_DIV-1; on the wrap, duty += 1. When duty reaches DUTY_MAX -> RUN. Stop, or go with a pair different from dir -> DEAD.
  - RUN: hb pair = dir, duty = DUTY_MAX. Stop or different pair -> DEAD. Same pair: stay.
  - DEAD: hb pair 00, en 0, duty cleared to 0, busy = 1; dead_cnt counts DEADTIME clocks. Command is ignored until the final DEAD clock, then re-sampled (last command wins): go -> RAMP with the newly latched dir, stop -> IDLE.
- hb_en[ch] = (state is RAMP or RUN) and (pwm_cnt < duty). Duty 0 gives constant low. Duty 2^PWM_BITS-1 gives high on all but one clock per period.
- hb_in pair is never 11 and never switches directly from 01 to 10 or 10 to 01. A DEAD interval of exactly DEADTIME clocks of 00 always separates the two.

## Timing
- Reset (asynchronous assert, synchronous release): hb_in = 0000, hb_en = 00, busy = 00, pwm_cnt = 0, both channels IDLE, duty/dir/counters 0. Reset mid-ramp or mid-DEAD returns to these values immediately.
- All outputs are registered. An input change is visible on hb_in/busy 3 clock edges later: 2 synchronizer edges plus 1 FSM edge.
- Ramp from IDLE to RUN takes DUTY_MAX × RAMP_DIV clocks after RAMP entry.
- DEAD lasts exactly DEADTIME clocks. busy rises on the same edge that hb pair goes to 00 and falls on the edge that leaves DEAD.
- Both channels may change state on the same clock; there is no shared arbitration.
- A command pulse shorter than one clock may be missed; this is acceptable because the upstream stage holds commands statically.

## Test plan
Bench parameters: PWM_BITS=4, DUTY_MAX=12, RAMP_DIV=4, DEADTIME=6.
- Reset: assert rst_n=0 mid-RAMP with hb_en toggling -> outputs go to 0000/00/00 asynchronously; after release, both channels stay IDLE with motor_en=00.
- Start: motor_in=0101, motor_en=11 -> hb_in=0101 at the 3rd edge; duty steps 0,1,...,12 every 4 clocks; RUN after 48 clocks; hb_en high for 12 of 16 clocks per period.
- Reversal in RUN: left pair 01 -> 10 -> left pair 00 with busy[1]=1 for exactly 6 clocks, then 10 with duty restarting at 0. Right channel is undisturbed.
- Stop: motor_en=00 during RAMP at duty 5 -> both channels 00 for 6 clocks, busy=11, then IDLE; hb_en stays 00 throughout.
- Command churn in DEAD: change 0110 -> 0000 -> 1010 within the DEAD window -> DEAD still lasts 6 clocks, then RAMP with 1010.
- Illegal pair: motor_in=1111 with motor_en=11 -> treated as stop; hb_in never 11, and 1111 applied from IDLE keeps the channels in IDLE.

Source files
------------

// File: rtl/rover_motor_pwm.sv
// rover_motor_pwm: two-channel H-bridge drive stage with soft-start duty
// ramping, a shared PWM counter and enforced dead time on every stop or
// direction reversal.
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   motor_in  command pairs, [3:2] left, [1:0] right (asynchronous to clk)
//   motor_en  command enables, [1] left, [0] right (asynchronous to clk)
//   hb_in     H-bridge direction pins, same mapping as motor_in (registered)
//   hb_en     H-bridge enable pins, PWM-modulated (registered)
//   busy      per channel, high while the channel is in dead time (registered)
module rover_motor_pwm #(
   parameter int unsigned PWM_BITS = 8,
   parameter int unsigned DUTY_MAX = 200,
   parameter int unsigned RAMP_DIV = 1000,
   parameter int unsigned DEADTIME = 50
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] motor_in,
   input  logic [1:0] motor_en,
   output logic [3:0] hb_in,
   output logic [1:0] hb_en,
   output logic [1:0] busy
);

   localparam int unsigned NCH    = 2;
   localparam int unsigned RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int unsigned DEAD_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RAMP = 2'd1,
      ST_RUN  = 2'd2,
      ST_DEAD = 2'd3
   } state_e;

   // Two-flop synchronizer stages
   logic [3:0] motor_in_s1_q, motor_in_s1_d;
   logic [3:0] motor_in_s2_q, motor_in_s2_d;
   logic [1:0] motor_en_s1_q, motor_en_s1_d;
   logic [1:0] motor_en_s2_q, motor_en_s2_d;

   // Shared PWM counter
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

   // Per-channel state
   state_e              state_q    [NCH];
   state_e              state_d    [NCH];
   logic [1:0]          dir_q      [NCH];
   logic [1:0]          dir_d      [NCH];
   logic [PWM_BITS-1:0] duty_q     [NCH];
   logic [PWM_BITS-1:0] duty_d     [NCH];
   logic [RAMP_W-1:0]   ramp_cnt_q [NCH];
   logic [RAMP_W-1:0]   ramp_cnt_d [NCH];
   logic [DEAD_W-1:0]   dead_cnt_q [NCH];
   logic [DEAD_W-1:0]   dead_cnt_d [NCH];

   // Registered outputs
   logic [3:0] hb_in_q, hb_in_d;
   logic [1:0] hb_en_q, hb_en_d;
   logic [1:0] busy_q, busy_d;

   // Decoded command per channel
   logic [1:0] cmd_pair [NCH];
   logic       cmd_go   [NCH];

   // Synchronizer and PWM counter next values
   always_comb begin
      motor_in_s1_d = motor_in;
      motor_in_s2_d = motor_in_s1_q;
      motor_en_s1_d = motor_en;
      motor_en_s2_d = motor_en_s1_q;
      pwm_cnt_d     = pwm_cnt_q + PWM_BITS'(1);
   end

   // Command decode: 01/10 with enable is go; 00, 11 or disabled is stop
   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         cmd_pair[c] = motor_in_s2_q[2*c +: 2];
         cmd_go[c]   = motor_en_s2_q[c] &&
                       ((cmd_pair[c] == 2'b01) || (cmd_pair[c] == 2'b10));
      end
   end

   // Per-channel next state and next outputs
   always_comb begin
      hb_in_d = '0;
      hb_en_d = '0;
      busy_d  = '0;
      for (int c = 0; c < NCH; c++) begin
         state_d[c]    = state_q[c];
         dir_d[c]      = dir_q[c];
         duty_d[c]     = duty_q[c];
         ramp_cnt_d[c] = ramp_cnt_q[c];
         dead_cnt_d[c] = dead_cnt_q[c];

         unique case (state_q[c])
            ST_IDLE: begin
               duty_d[c] = '0;
               if (cmd_go[c]) begin
                  state_d[c]    = ST_RAMP;
                  dir_d[c]      = cmd_pair[c];
                  ramp_cnt_d[c] = '0;
               end
            end

            ST_RAMP: begin
               if (!cmd_go[c] || (cmd_pair[c] != dir_q[c])) begin
                  state_d[c]    = ST_DEAD;
                  duty_d[c]     = '0;
                  dead_cnt_d[c] = '0;
               end else if (ramp_cnt_q[c] == RAMP_W'(RAMP_DIV - 1)) begin
                  ramp_cnt_d[c] = '0;
                  duty_d[c]     = duty_q[c] + PWM_BITS'(1);
                  if ((duty_q[c] + PWM_BITS'(1)) == PWM_BITS'(DUTY_MAX)) begin
                     state_d[c] = ST_RUN;
                  end
               end else begin
                  ramp_cnt_d[c] = ramp_cnt_q[c] + RAMP_W'(1);
               end
            end

            ST_RUN: begin
               duty_d[c] = PWM_BITS'(DUTY_MAX);
               if (!cmd_go[c] || (cmd_pair[c] != dir_q[c])) begin
                  state_d[c]    = ST_DEAD;
                  duty_d[c]     = '0;
                  dead_cnt_d[c] = '0;
               end
            end

            ST_DEAD: begin
               duty_d[c] = '0;
               // Command is only looked at on the last dead-time clock
               if (dead_cnt_q[c] == DEAD_W'(DEADTIME - 1)) begin
                  dead_cnt_d[c] = '0;
                  if (cmd_go[c]) begin
                     state_d[c]    = ST_RAMP;
                     dir_d[c]      = cmd_pair[c];
                     ramp_cnt_d[c] = '0;
                  end else begin
                     state_d[c] = ST_IDLE;
                  end
               end else begin
                  dead_cnt_d[c] = dead_cnt_q[c] + DEAD_W'(1);
               end
            end

            default: begin
               state_d[c] = ST_IDLE;
               duty_d[c]  = '0;
            end
         endcase

         // Outputs are derived from next-state values so they register with it
         if ((state_d[c] == ST_RAMP) || (state_d[c] == ST_RUN)) begin
            hb_in_d[2*c +: 2] = dir_d[c];
            hb_en_d[c]        = (pwm_cnt_d < duty_d[c]);
         end
         busy_d[c] = (state_d[c] == ST_DEAD);
      end
   end

   // Register bank
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         motor_in_s1_q <= '0;
         motor_in_s2_q <= '0;
         motor_en_s1_q <= '0;
         motor_en_s2_q <= '0;
         pwm_cnt_q     <= '0;
         hb_in_q       <= '0;
         hb_en_q       <= '0;
         busy_q        <= '0;
         for (int c = 0; c < NCH; c++) begin
            state_q[c]    <= ST_IDLE;
            dir_q[c]      <= '0;
            duty_q[c]     <= '0;
            ramp_cnt_q[c] <= '0;
            dead_cnt_q[c] <= '0;
         end
      end else begin
         motor_in_s1_q <= motor_in_s1_d;
         motor_in_s2_q <= motor_in_s2_d;
         motor_en_s1_q <= motor_en_s1_d;
         motor_en_s2_q <= motor_en_s2_d;
         pwm_cnt_q     <= pwm_cnt_d;
         hb_in_q       <= hb_in_d;
         hb_en_q       <= hb_en_d;
         busy_q        <= busy_d;
         for (int c = 0; c < NCH; c++) begin
            state_q[c]    <= state_d[c];
            dir_q[c]      <= dir_d[c];
            duty_q[c]     <= duty_d[c];
            ramp_cnt_q[c] <= ramp_cnt_d[c];
            dead_cnt_q[c] <= dead_cnt_d[c];
         end
      end
   end

   assign hb_in = hb_in_q;
   assign hb_en = hb_en_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_rover_motor_pwm.sv
// Bench for rover_motor_pwm with PWM_BITS=4, DUTY_MAX=12, RAMP_DIV=4,
// DEADTIME=6. Stimulus pushes hand-computed expectations tagged with the
// clock count at which they must hold; a monitor on the falling edge pops
// and compares them, and also checks the bridge-pair safety rules.
// Reset is released right after edge 3, so pwm_cnt after edge c is (c-3)%16.
module tb_rover_motor_pwm;

   logic       clk;
   logic       rst_n;
   logic [3:0] motor_in;
   logic [1:0] motor_en;
   logic [3:0] hb_in;
   logic [1:0] hb_en;
   logic [1:0] busy;

   rover_motor_pwm #(
      .PWM_BITS(4),
      .DUTY_MAX(12),
      .RAMP_DIV(4),
      .DEADTIME(6)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .motor_in(motor_in),
      .motor_en(motor_en),
      .hb_in   (hb_in),
      .hb_en   (hb_en),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      int         kind;   // 0 = output snapshot, 1 = 16-clock hb_en count
      logic [3:0] hb_in;
      logic [1:0] hb_en;
      logic [1:0] busy;
      int         cnt1;
      int         cnt0;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   logic [1:0] hist [0:511];
   logic [3:0] prev_hb_in = 4'b0000;

   task automatic push_snap(input int c, input logic [3:0] hi,
                            input logic [1:0] he, input logic [1:0] bz);
      exp_t e;
      e.cyc = c; e.kind = 0; e.hb_in = hi; e.hb_en = he; e.busy = bz;
      e.cnt1 = 0; e.cnt0 = 0;
      sb.push_back(e);
   endtask

   task automatic push_win(input int c, input int n1, input int n0);
      exp_t e;
      e.cyc = c; e.kind = 1; e.hb_in = '0; e.hb_en = '0; e.busy = '0;
      e.cnt1 = n1; e.cnt0 = n0;
      sb.push_back(e);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input logic [3:0] mi, input logic [1:0] me);
      motor_in = mi;
      motor_en = me;
   endtask

   // Monitor: scoreboard compare plus bridge safety rules
   always @(negedge clk) begin
      hist[cyc % 512] = hb_en;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            if (sb[i].kind == 0) begin
               checks++;
               if (hb_in !== sb[i].hb_in || hb_en !== sb[i].hb_en || busy !== sb[i].busy) begin
                  errors++;
                  $display("FAIL snap@%0d: hb_in=%b hb_en=%b busy=%b expected hb_in=%b hb_en=%b busy=%b",
                           cyc, hb_in, hb_en, busy, sb[i].hb_in, sb[i].hb_en, sb[i].busy);
               end
            end else begin
               int n1, n0;
               n1 = 0; n0 = 0;
               for (int k = 0; k < 16; k++) begin
                  n1 += int'(hist[(cyc - k) % 512][1]);
                  n0 += int'(hist[(cyc - k) % 512][0]);
               end
               checks++;
               if (n1 != sb[i].cnt1 || n0 != sb[i].cnt0) begin
                  errors++;
                  $display("FAIL win@%0d: hb_en high count left=%0d right=%0d expected left=%0d right=%0d",
                           cyc, n1, n0, sb[i].cnt1, sb[i].cnt0);
               end
            end
            sb.delete(i);
         end
      end
      if (rst_n) begin
         for (int ch = 0; ch < 2; ch++) begin
            logic [1:0] p, q;
            p = hb_in[2*ch +: 2];
            q = prev_hb_in[2*ch +: 2];
            checks++;
            if (p == 2'b11 || (q == 2'b01 && p == 2'b10) || (q == 2'b10 && p == 2'b01)) begin
               errors++;
               $display("FAIL pair@%0d ch%0d: went %b -> %b, required no 11 and no direct reversal",
                        cyc, ch, q, p);
            end
         end
      end
      prev_hb_in = rst_n ? hb_in : 4'b0000;
   end

   initial begin
      rst_n = 1'b0;
      drive(4'b0000, 2'b00);

      // Reset values, then idle with enables low
      wait_until(3);
      push_snap(3, 4'b0000, 2'b00, 2'b00);
      push_snap(8, 4'b0000, 2'b00, 2'b00);
      rst_n = 1'b1;

      // Start both channels; RAMP entry at edge 19 lines up with pwm_cnt=0
      push_snap(18, 4'b0000, 2'b00, 2'b00);
      push_snap(19, 4'b0101, 2'b00, 2'b00);
      push_win(34, 0, 0);                    // duty 0..3
      push_win(50, 5, 5);                    // duty 4..7
      push_snap(59, 4'b0101, 2'b11, 2'b00);  // pwm 8 < duty 10
      push_snap(62, 4'b0101, 2'b00, 2'b00);  // pwm 11, duty 10
      push_win(66, 10, 10);                  // duty 8..11
      push_snap(67, 4'b0101, 2'b11, 2'b00);  // RUN, duty 12, pwm 0
      push_snap(79, 4'b0101, 2'b00, 2'b00);  // pwm 12 not < 12
      push_win(82, 12, 12);
      push_win(98, 12, 12);
      wait_until(16);
      drive(4'b0101, 2'b11);

      // Left reversal in RUN; right channel keeps running
      push_snap(102, 4'b0101, 2'b11, 2'b00);
      push_snap(103, 4'b0001, 2'b01, 2'b10);
      push_snap(108, 4'b0001, 2'b01, 2'b10);
      push_snap(109, 4'b1001, 2'b01, 2'b00);
      push_win(118, 1, 12);
      wait_until(100);
      drive(4'b1001, 2'b11);

      // Stop both (left RAMP, right RUN)
      push_snap(122, 4'b1001, 2'b01, 2'b00);
      push_snap(123, 4'b0000, 2'b00, 2'b11);
      push_snap(128, 4'b0000, 2'b00, 2'b11);
      push_snap(129, 4'b0000, 2'b00, 2'b00);
      wait_until(120);
      drive(4'b1001, 2'b00);

      // Stop during RAMP at duty 5
      push_snap(143, 4'b0101, 2'b00, 2'b00);
      push_snap(162, 4'b0101, 2'b00, 2'b00);
      push_snap(163, 4'b0101, 2'b11, 2'b00);
      push_snap(164, 4'b0000, 2'b00, 2'b11);
      push_snap(166, 4'b0000, 2'b00, 2'b11);
      push_snap(169, 4'b0000, 2'b00, 2'b11);
      push_snap(170, 4'b0000, 2'b00, 2'b00);
      push_win(179, 0, 0);
      wait_until(140);
      drive(4'b0101, 2'b11);
      wait_until(161);
      drive(4'b0101, 2'b00);

      // Command churn while in DEAD: last command wins
      push_snap(183, 4'b0101, 2'b00, 2'b00);
      push_snap(192, 4'b0101, 2'b00, 2'b00);
      push_snap(193, 4'b0100, 2'b00, 2'b01);
      push_snap(195, 4'b0000, 2'b00, 2'b11);
      push_snap(198, 4'b0000, 2'b00, 2'b11);
      push_snap(199, 4'b0010, 2'b00, 2'b10);
      push_snap(200, 4'b0010, 2'b00, 2'b10);
      push_snap(201, 4'b1010, 2'b00, 2'b00);
      wait_until(180);
      drive(4'b0101, 2'b11);
      wait_until(190);
      drive(4'b0110, 2'b11);
      wait_until(192);
      drive(4'b0000, 2'b11);
      wait_until(194);
      drive(4'b1010, 2'b11);

      // Illegal pair 11 acts as stop, and keeps IDLE channels idle
      push_snap(212, 4'b1010, 2'b11, 2'b00);
      push_snap(213, 4'b0000, 2'b00, 2'b11);
      push_snap(218, 4'b0000, 2'b00, 2'b11);
      push_snap(219, 4'b0000, 2'b00, 2'b00);
      push_snap(230, 4'b0000, 2'b00, 2'b00);
      push_snap(245, 4'b0000, 2'b00, 2'b00);
      wait_until(210);
      drive(4'b1111, 2'b11);
      wait_until(232);
      drive(4'b0000, 2'b00);
      wait_until(236);
      drive(4'b1111, 2'b11);

      // Asynchronous reset mid-RAMP while hb_en toggles
      push_snap(279, 4'b0101, 2'b11, 2'b00);
      push_snap(280, 4'b0000, 2'b00, 2'b00);
      push_snap(281, 4'b0000, 2'b00, 2'b00);
      push_snap(291, 4'b0000, 2'b00, 2'b00);
      push_snap(300, 4'b0000, 2'b00, 2'b00);
      wait_until(250);
      drive(4'b0101, 2'b11);
      wait_until(280);
      #1;
      rst_n = 1'b0;
      drive(4'b0000, 2'b00);
      wait_until(285);
      rst_n = 1'b1;

      wait_until(310);
      @(negedge clk);
      #1;
      foreach (sb[i]) begin
         checks++;
         errors++;
         $display("FAIL unchecked@%0d: expectation never reached, current cycle %0d", sb[i].cyc, cyc);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
